// File: rtl/knn_pkg.sv
// Shared definitions for the k-NN datapath: fetch FSM encoding, sample
// stride and packed-word slicing helpers used by the fetch and distance stages.
// Latency: n/a (types and constant functions only). Backpressure: n/a.
package knn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } fetch_state_t;

  // Default stride for M=N=2; modules with other geometries use sample_stride().
  localparam int SAMPLE_STRIDE = 2 * 2 + 1;

  // Memory words per training sample: M*N feature words plus one type word.
  function automatic int sample_stride(input int m, input int n);
    return m * n + 1;
  endfunction

  // Low bit of packed word j in a vector of w-bit words.
  function automatic int word_lo(input int j, input int w);
    return j * w;
  endfunction

endpackage

// File: rtl/training_data_fetch.sv
// Reads one training sample (M*N feature words + type word) per request and commits it.
// Latency: request sampled at edge k gives read_done in cycle k+M*N+3; one sample per M*N+4 cycles.
// Backpressure: data_request is a level sampled only in IDLE; requests are ignored once exhausted.
//
// Ports: clk/rst (sync, active-high); restart rewinds the sample index; data_request asks for
// the next sample; mem_en/mem_addr/mem_rdata form a 1-cycle-latency read port; training_data,
// training_data_type hold the last committed sample; read_done pulses on commit; exhausted is a level.
module training_data_fetch
  import knn_pkg::*;
#(
  parameter int M            = 2,
  parameter int N            = 2,
  parameter int W            = 8,
  parameter int TYPE_W       = 2,
  parameter int MAX_ELEMENTS = 16,
  parameter int MEM_AW       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                restart,
  input  logic                data_request,
  output logic                mem_en,
  output logic [MEM_AW-1:0]   mem_addr,
  input  logic [W-1:0]        mem_rdata,
  output logic [W*M*N-1:0]    training_data,
  output logic [TYPE_W-1:0]   training_data_type,
  output logic                read_done,
  output logic                exhausted
);

  localparam int WORDS = M * N;
  localparam int CW    = $clog2(WORDS + 1);
  localparam int IW    = $clog2(MAX_ELEMENTS + 1);

  localparam logic [CW-1:0]     LAST_CNT = CW'(WORDS);
  localparam logic [IW-1:0]     LAST_IDX = IW'(MAX_ELEMENTS);
  localparam logic [MEM_AW-1:0] STRIDE_A = MEM_AW'(sample_stride(M, N));

  fetch_state_t        state;
  logic [CW-1:0]       cnt;          // word index currently on mem_addr
  logic                cap_vld;      // mem_rdata carries a word this cycle
  logic [CW-1:0]       cap_idx;      // which word of the sample mem_rdata holds
  logic [W*M*N-1:0]    shadow;
  logic [IW-1:0]       idx;
  logic [MEM_AW-1:0]   base;         // running s*(M*N+1), avoids a multiplier
  logic                restart_pend; // restart seen mid-fetch, applied on return to IDLE

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      cap_vld            <= 1'b0;
      cap_idx            <= '0;
      shadow             <= '0;
      idx                <= '0;
      base               <= '0;
      restart_pend       <= 1'b0;
      mem_en             <= 1'b0;
      mem_addr           <= '0;
      training_data      <= '0;
      training_data_type <= '0;
      read_done          <= 1'b0;
      exhausted          <= 1'b0;
    end else begin
      // Read data trails its address by one cycle, so the capture pipeline
      // follows mem_en/cnt by one stage.
      cap_vld   <= mem_en;
      cap_idx   <= cnt;
      read_done <= 1'b0;

      if (cap_vld && cap_idx != LAST_CNT) begin
        shadow[word_lo(int'(cap_idx), W) +: W] <= mem_rdata;
      end

      if (state != IDLE && restart) begin
        restart_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (restart) begin
            idx       <= '0;
            base      <= '0;
            exhausted <= 1'b0;
          end else if (data_request && !exhausted) begin
            state    <= FETCH;
            mem_en   <= 1'b1;
            mem_addr <= base;
            cnt      <= '0;
          end
        end

        FETCH: begin
          if (cnt == LAST_CNT) begin
            state    <= DRAIN;
            mem_en   <= 1'b0;
            mem_addr <= '0;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            cnt      <= cnt + 1'b1;
          end
        end

        DRAIN: begin
          // The type word is on mem_rdata now; it goes straight into the
          // committed output together with the shadow, so everything becomes
          // visible in the COMMIT cycle alongside read_done.
          training_data      <= shadow;
          training_data_type <= mem_rdata[TYPE_W-1:0];
          read_done          <= 1'b1;
          idx                <= idx + 1'b1;
          base               <= base + STRIDE_A;
          exhausted          <= ((idx + 1'b1) == LAST_IDX);
          state              <= COMMIT;
        end

        COMMIT: begin
          // A rewind requested during this sample overrides the increment.
          if (restart || restart_pend) begin
            idx       <= '0;
            base      <= '0;
            exhausted <= 1'b0;
          end
          restart_pend <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_training_data_fetch.sv
// Directed bench for training_data_fetch with M=N=2, W=8, TYPE_W=2, MAX_ELEMENTS=3.
// Sample s holds words 8'h10*s+1..+4 then type word 8'hF0|s in a 1-cycle-latency memory.
// Outputs are sampled 1 time unit after each rising edge.
module tb_training_data_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        data_request = 1'b0;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [31:0] training_data;
  logic [1:0]  training_data_type;
  logic        read_done;
  logic        exhausted;

  logic [7:0]  mem [0:15];
  int          checks = 0;
  int          errors = 0;

  training_data_fetch #(
    .M(2), .N(2), .W(8), .TYPE_W(2), .MAX_ELEMENTS(3), .MEM_AW(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .restart(restart),
    .data_request(data_request),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .training_data(training_data),
    .training_data_type(training_data_type),
    .read_done(read_done),
    .exhausted(exhausted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr[3:0]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps until read_done is seen, up to max cycles; n is the cycle count.
  task automatic wait_done(input string tag, input int max, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int i = 1; i <= max && !got; i++) begin
      step();
      if (read_done) begin
        got = 1'b1;
        n = i;
      end
    end
    check({tag, "_seen"}, {63'd0, got}, 64'd1);
  endtask

  function automatic logic [31:0] sample_data(input int s);
    logic [7:0] b;
    b = 8'(16 * s);
    return {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1};
  endfunction

  initial begin
    int n;
    int np;
    int prev;
    int en_cnt;
    int en_after;
    int rd_cnt;

    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 4; j++) mem[s*5 + j] = 8'(16 * s + j + 1);
      mem[s*5 + 4] = 8'hF0 | 8'(s);
    end
    mem[15] = 8'h00;

    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_mem_en", {63'd0, mem_en}, 64'd0);
    check("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
    check("rst_data", {32'd0, training_data}, 64'd0);
    check("rst_type", {62'd0, training_data_type}, 64'd0);
    check("rst_read_done", {63'd0, read_done}, 64'd0);
    check("rst_exhausted", {63'd0, exhausted}, 64'd0);

    // 1. Single request: addresses 0..4 in k+1..k+5, read_done at k+7
    data_request = 1'b1;
    step();
    data_request = 1'b0;
    check("t1_en0", {63'd0, mem_en}, 64'd1);
    check("t1_addr0", {48'd0, mem_addr}, 64'd0);
    for (int a = 1; a <= 4; a++) begin
      step();
      check("t1_addr", {48'd0, mem_addr}, 64'(a));
    end
    step();
    check("t1_drain_en", {63'd0, mem_en}, 64'd0);
    check("t1_drain_done", {63'd0, read_done}, 64'd0);
    check("t1_data_hold", {32'd0, training_data}, 64'd0);
    step();
    check("t1_done", {63'd0, read_done}, 64'd1);
    check("t1_data", {32'd0, training_data}, 64'h04030201);
    check("t1_type", {62'd0, training_data_type}, 64'd0);
    step();
    check("t1_done_pulse", {63'd0, read_done}, 64'd0);
    check("t1_data_kept", {32'd0, training_data}, 64'h04030201);

    // 2. Rewind, then hold request high for the whole pass
    restart = 1'b1;
    step();
    restart = 1'b0;
    data_request = 1'b1;
    np = 0; prev = 0; en_cnt = 0; en_after = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (mem_en) begin
        en_cnt++;
        if (np == 3) en_after++;
      end
      if (read_done) begin
        check("t2_data", {32'd0, training_data}, {32'd0, sample_data(np)});
        check("t2_type", {62'd0, training_data_type}, 64'(np));
        check("t2_exh", {63'd0, exhausted}, (np == 2) ? 64'd1 : 64'd0);
        if (np == 0) check("t2_first_lat", 64'(i), 64'd6);
        else check("t2_gap", 64'(i - prev), 64'd8);
        prev = i;
        np++;
      end
    end
    check("t2_pulses", 64'(np), 64'd3);
    check("t2_en_cycles", 64'(en_cnt), 64'd15);
    check("t2_en_after_exh", 64'(en_after), 64'd0);
    check("t2_exh_level", {63'd0, exhausted}, 64'd1);

    // 3. Restart while exhausted, then request: sample 0 again
    data_request = 1'b0;
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("t3_exh_clr", {63'd0, exhausted}, 64'd0);
    check("t3_data_kept", {32'd0, training_data}, 64'h24232221);
    data_request = 1'b1;
    step();
    data_request = 1'b0;
    check("t3_en", {63'd0, mem_en}, 64'd1);
    check("t3_addr", {48'd0, mem_addr}, 64'd0);
    wait_done("t3", 12, n);
    check("t3_lat", 64'(n), 64'd6);
    check("t3_data", {32'd0, training_data}, 64'h04030201);
    step();

    // 4. Restart during FETCH of sample 1
    data_request = 1'b1;
    step();
    data_request = 1'b0;
    check("t4_addr", {48'd0, mem_addr}, 64'd5);
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    wait_done("t4", 12, n);
    check("t4_data", {32'd0, training_data}, 64'h14131211);
    check("t4_type", {62'd0, training_data_type}, 64'd1);
    check("t4_exh", {63'd0, exhausted}, 64'd0);
    step();
    data_request = 1'b1;
    step();
    data_request = 1'b0;
    check("t4_rewind_addr", {48'd0, mem_addr}, 64'd0);
    check("t4_rewind_en", {63'd0, mem_en}, 64'd1);

    // 5. Reset mid-FETCH
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_en", {63'd0, mem_en}, 64'd0);
    check("t5_addr", {48'd0, mem_addr}, 64'd0);
    check("t5_data", {32'd0, training_data}, 64'd0);
    check("t5_type", {62'd0, training_data_type}, 64'd0);
    check("t5_done", {63'd0, read_done}, 64'd0);
    rd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (read_done || mem_en) rd_cnt++;
    end
    check("t5_quiet", 64'(rd_cnt), 64'd0);
    data_request = 1'b1;
    step();
    data_request = 1'b0;
    check("t5_addr0", {48'd0, mem_addr}, 64'd0);
    wait_done("t5", 12, n);
    check("t5_redeliver", {32'd0, training_data}, 64'h04030201);
    step();

    // 6. Type word with upper bits set
    mem[4] = 8'hF3;
    restart = 1'b1;
    step();
    restart = 1'b0;
    data_request = 1'b1;
    step();
    data_request = 1'b0;
    wait_done("t6", 12, n);
    check("t6_type", {62'd0, training_data_type}, 64'd3);
    check("t6_data", {32'd0, training_data}, 64'h04030201);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
